// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register bank slave.
// Holds the FSM state type and the address/lane arithmetic.
package apb_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int lane_lsb(input int lane);
    return lane * 8;
  endfunction

  function automatic logic misaligned(
    input logic [31:0] addr,
    input int          lsb
  );
    logic [31:0] m;
    m = (32'd1 << lsb) - 32'd1;
    return (addr & m) != 32'd0;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state down-counter for the APB register bank slave.
// Loaded at setup; done flags the last wait cycle.
module apb_wait_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave exposing a bank of byte-strobed registers.
// Register 0 is a read-only ID; wait states are programmable.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h0000_0006,
  parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(1)
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [31:0]                PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W-1:0]          PRDATA,
  input  logic [DATA_W/8-1:0]        PSTRB,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] REGS_OUT
);

  localparam int LSB   = addr_lsb(DATA_W);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB    = DATA_W / 8;

  state_t              state;
  logic [31:0]         addr_q;
  logic                write_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       strb_q;
  logic [IDX_W-1:0]    idx_q;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   view [NUM_REGS];

  logic [31:0]         cur_addr;
  logic                cur_write;
  logic [31:0]         word;
  logic [IDX_W-1:0]    idx_c;
  logic                in_range;
  logic                err_c;
  logic [DATA_W-1:0]   rd_c;
  logic                setup;
  logic                done;
  logic                enter_resp;
  logic                commit;

  // WAIT_STATES=0 enters RESP from IDLE, so decode the live bus there.
  assign cur_addr  = (state == IDLE) ? PADDR : addr_q;
  assign cur_write = (state == IDLE) ? PWRITE : write_q;

  // Full word compare so high address bits cannot alias into range.
  assign word     = cur_addr >> LSB;
  assign idx_c    = word[IDX_W-1:0];
  assign in_range = word < 32'(NUM_REGS);

  assign err_c = misaligned(cur_addr, LSB) || !in_range ||
                 (cur_write && (idx_c == '0 || RO_MASK[idx_c]));

  assign rd_c  = view[idx_c];
  assign setup = PSEL && !PENABLE;

  assign enter_resp =
    (state == IDLE && setup && WAIT_STATES == 0) ||
    (state == WAIT && PSEL && done);

  assign commit = (state == RESP) && PSEL && write_q && !err_q;

  apb_wait_ctr #(
    .CNT_W(4)
  ) u_wait_ctr (
    .clk      (PCLK),
    .rst_n    (PRESET),
    .load     (state == IDLE && setup),
    .dec      (state == WAIT && PSEL),
    .load_val (4'(WAIT_STATES)),
    .done     (done)
  );

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state   <= IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else begin
      PREADY  <= enter_resp;
      PSLVERR <= enter_resp && err_c;
      if (enter_resp && !cur_write) begin
        PRDATA <= err_c ? '0 : rd_c;
      end
      unique case (state)
        IDLE: begin
          if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            err_q   <= err_c;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            idx_q   <= idx_c;
            state   <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (done) begin
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) begin
          regs[idx_q][lane_lsb(b) +: 8] <=
            wdata_q[lane_lsb(b) +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = regs[i];
    end
    view[0] = ID_VALUE[DATA_W-1:0];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign REGS_OUT[g*DATA_W +: DATA_W] = view[g];
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave.
// dut_a uses one wait state, dut_b uses zero wait states.
module tb_apb_regbank_slave;

  logic         clk;
  logic         rst_n;
  logic         psel_a;
  logic         psel_b;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata_a;
  logic [31:0]  prdata_b;
  logic         pready_a;
  logic         pready_b;
  logic         pslverr_a;
  logic         pslverr_b;
  logic [255:0] regs_a;
  logic [255:0] regs_b;
  logic [255:0] exp_a;

  int n_cmp;
  int n_bad;

  apb_regbank_slave #(
    .WAIT_STATES(1)
  ) dut_a (
    .PCLK     (clk),
    .PRESET   (rst_n),
    .PSEL     (psel_a),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PADDR    (paddr),
    .PWDATA   (pwdata),
    .PRDATA   (prdata_a),
    .PSTRB    (pstrb),
    .PREADY   (pready_a),
    .PSLVERR  (pslverr_a),
    .REGS_OUT (regs_a)
  );

  apb_regbank_slave #(
    .WAIT_STATES(0)
  ) dut_b (
    .PCLK     (clk),
    .PRESET   (rst_n),
    .PSEL     (psel_b),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PADDR    (paddr),
    .PWDATA   (pwdata),
    .PRDATA   (prdata_b),
    .PSTRB    (pstrb),
    .PREADY   (pready_b),
    .PSLVERR  (pslverr_b),
    .REGS_OUT (regs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; returns at posedge+1 after the RESP-exit edge.
  task automatic xfer(
    input  bit          b,
    input  bit          wr,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [31:0] rd,
    output logic        er,
    output int          rc
  );
    int cyc;
    if (b) psel_b = 1'b1;
    else   psel_a = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    while (!(b ? pready_b : pready_a) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rc = (b ? pready_b : pready_a) ? cyc : -1;
    rd = b ? prdata_b : prdata_a;
    er = b ? pslverr_b : pslverr_a;
    @(posedge clk); #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    exp_a   = 256'h6;
    #7;
    n_cmp++;
    if (pready_a !== 1'b0 || pslverr_a !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b%b want 00", pready_a, pslverr_a);
    end
    n_cmp++;
    if (prdata_a !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_prdata got %h want 0", prdata_a);
    end
    n_cmp++;
    if (regs_a !== exp_a || regs_b !== exp_a) begin
      n_bad++;
      $display("FAIL rst_regs got %h want %h", regs_a, exp_a);
    end
    #15 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic        er;
    int          rc;
    xfer(0, 1, 32'h4, 32'h2012_2023, 4'hf, rd, er, rc);
    exp_a[63:32] = 32'h2012_2023;
    n_cmp++;
    if (rc !== 2 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL wr4 got rc=%0d err=%b want 2 0", rc, er);
    end
    xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, rc);
    n_cmp++;
    if (rc !== 2 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL rd4_hs got rc=%0d err=%b want 2 0", rc, er);
    end
    n_cmp++;
    if (rd !== 32'h2012_2023) begin
      n_bad++;
      $display("FAIL rd4_data got %h want 20122023", rd);
    end
  endtask

  task automatic test_strobe;
    logic [31:0] rd;
    logic        er;
    int          rc;
    xfer(0, 1, 32'h8, 32'hAABB_CCDD, 4'b0101, rd, er, rc);
    exp_a[95:64] = 32'h00BB_00DD;
    xfer(0, 0, 32'h8, 32'h0, 4'h0, rd, er, rc);
    n_cmp++;
    if (rd !== 32'h00BB_00DD || er !== 1'b0) begin
      n_bad++;
      $display("FAIL strb got %h err=%b want 00bb00dd 0", rd, er);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic        er;
    int          rc;
    xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, er, rc);
    n_cmp++;
    if (er !== 1'b1 || rc !== 2 || rd !== 32'h0) begin
      n_bad++;
      $display("FAIL err_rd20 got err=%b rc=%0d rd=%h want 1 2 0",
               er, rc, rd);
    end
    xfer(0, 1, 32'h6, 32'hFFFF_FFFF, 4'hf, rd, er, rc);
    n_cmp++;
    if (er !== 1'b1 || rc !== 2) begin
      n_bad++;
      $display("FAIL err_wr6 got err=%b rc=%0d want 1 2", er, rc);
    end
    xfer(0, 1, 32'h0, 32'hFFFF_FFFF, 4'hf, rd, er, rc);
    n_cmp++;
    if (er !== 1'b1 || rc !== 2) begin
      n_bad++;
      $display("FAIL err_wr0 got err=%b rc=%0d want 1 2", er, rc);
    end
    n_cmp++;
    if (regs_a !== exp_a) begin
      n_bad++;
      $display("FAIL err_regs got %h want %h", regs_a, exp_a);
    end
    xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, er, rc);
    n_cmp++;
    if (rd !== 32'h6 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL id_rd got %h err=%b want 6 0", rd, er);
    end
    n_cmp++;
    if (pslverr_a !== 1'b0 || pready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_flags got %b%b want 00", pready_a, pslverr_a);
    end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    logic        er;
    int          rc;
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'hC;
    pwdata  = 32'h1234_5678;
    pstrb   = 4'hf;
    @(posedge clk); #1;
    psel_a  = 1'b0;
    n_cmp++;
    if (pready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_wait got %b want 0", pready_a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (pready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_exit got %b want 0", pready_a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (pready_a !== 1'b0 || regs_a !== exp_a) begin
      n_bad++;
      $display("FAIL abort_regs rdy=%b got %h want %h",
               pready_a, regs_a, exp_a);
    end
    xfer(0, 0, 32'hC, 32'h0, 4'h0, rd, er, rc);
    n_cmp++;
    if (rd !== 32'h0 || er !== 1'b0 || rc !== 2) begin
      n_bad++;
      $display("FAIL abort_rd got %h err=%b rc=%0d want 0 0 2",
               rd, er, rc);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic        er;
    int          rc0;
    int          rc1;
    xfer(1, 1, 32'h4, 32'hCAFE_0001, 4'hf, rd, er, rc0);
    xfer(1, 1, 32'h8, 32'hBEEF_0002, 4'hf, rd, er, rc1);
    n_cmp++;
    if (rc0 !== 1 || rc1 !== 1) begin
      n_bad++;
      $display("FAIL b2b_rdy got %0d %0d want 1 1", rc0, rc1);
    end
    xfer(1, 0, 32'h4, 32'h0, 4'h0, rd, er, rc0);
    n_cmp++;
    if (rd !== 32'hCAFE_0001 || rc0 !== 1) begin
      n_bad++;
      $display("FAIL b2b_rd4 got %h rc=%0d want cafe0001 1", rd, rc0);
    end
    xfer(1, 0, 32'h8, 32'h0, 4'h0, rd, er, rc1);
    n_cmp++;
    if (rd !== 32'hBEEF_0002 || rc1 !== 1) begin
      n_bad++;
      $display("FAIL b2b_rd8 got %h rc=%0d want beef0002 1", rd, rc1);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic        er;
    int          rc;
    logic [31:0] want;
    xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, rc);
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h14;
    pwdata  = 32'hDEAD_BEEF;
    pstrb   = 4'hf;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_a = 256'h6;
    n_cmp++;
    if (pready_a !== 1'b0 || pslverr_a !== 1'b0 ||
        prdata_a !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_rst_out got %b %b %h want 0 0 0",
               pready_a, pslverr_a, prdata_a);
    end
    n_cmp++;
    if (regs_a !== exp_a || regs_b !== exp_a) begin
      n_bad++;
      $display("FAIL mid_rst_regs got %h want %h", regs_a, exp_a);
    end
    psel_a  = 1'b0;
    penable = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      want = (i == 0) ? 32'h6 : 32'h0;
      xfer(0, 0, 32'(i * 4), 32'h0, 4'h0, rd, er, rc);
      n_cmp++;
      if (rd !== want || er !== 1'b0) begin
        n_bad++;
        $display("FAIL post_rst_rd%0d got %h want %h", i, rd, want);
      end
    end
    n_cmp++;
    if (regs_a !== exp_a) begin
      n_bad++;
      $display("FAIL post_rst_regs got %h want %h", regs_a, exp_a);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_regbank_slave.md
APB_REGBANK_SLAVE -- requirements
Module: apb_regbank_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits (8, 16 or 32).
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning number of registers (2..256).
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning PREADY-low access cycles per transfer (0..15).
REQ-004 SHALL have parameter ID_VALUE, default 32'h0000_0006, meaning constant returned by register 0.
REQ-005 SHALL have parameter RO_MASK, default NUM_REGS'b1, meaning set bit i makes register i read-only.
REQ-006 SHALL have port PCLK, input, 1, meaning the single clock, all logic on rising edge.
REQ-007 SHALL have port PRESET, input, 1, meaning reset: asynchronous, active-low.
REQ-008 SHALL have ports PSEL, PENABLE and PWRITE, each input, 1, meaning the APB select, enable and write strobe (1 = write).
REQ-009 SHALL have port PADDR, input, 32, meaning byte address.
REQ-010 SHALL have ports PWDATA (input, DATA_W) and PRDATA (output, DATA_W), meaning write data and registered read data.
REQ-011 SHALL have port PSTRB, input, DATA_W/8, meaning byte-lane write enables.
REQ-012 SHALL have ports PREADY and PSLVERR, each output, 1, meaning transfer completion and transfer error.
REQ-013 SHALL have port REGS_OUT, output, NUM_REGS*DATA_W, meaning flat live copy of all registers, register i in bits [i*DATA_W +: DATA_W].

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE, PSEL=1 with PENABLE=0 (setup) SHALL latch address, direction, data and strobe, load the wait counter with WAIT_STATES, and go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-016 WAIT SHALL decrement the counter each cycle and move to RESP at the edge where the counter reaches 1.
REQ-017 PREADY SHALL be registered and 1 only in RESP, giving exactly WAIT_STATES PREADY-low access cycles.
REQ-018 RESP SHALL return to IDLE at the next edge unconditionally; a following setup is accepted from IDLE (back-to-back supported).
REQ-019 Register index SHALL be PADDR[LSB +: IDX_W] with LSB = log2(DATA_W/8).
REQ-020 A transfer SHALL be an error if PADDR[LSB-1:0] != 0, the index >= NUM_REGS, or it is a write to a RO_MASK register.
REQ-021 PSLVERR SHALL equal the error flag while PREADY=1 and be 0 otherwise.
REQ-022 A non-error write SHALL commit at the RESP-exit edge, updating only byte lanes with PSTRB=1; an error write SHALL change nothing.
REQ-023 Read data SHALL load into PRDATA on entry to RESP, PRDATA=0 on error, and PRDATA SHALL hold its value outside RESP.
REQ-024 Register 0 SHALL read ID_VALUE and never be writable, regardless of RO_MASK.
REQ-025 PSEL=0 in WAIT or RESP SHALL abort to IDLE at the next edge with no commit and PREADY=0.
REQ-026 PENABLE=1 seen in IDLE without a preceding setup SHALL be ignored.

Reset
REQ-027 PRESET=0 SHALL immediately force: state IDLE, counter 0, PREADY=0, PSLVERR=0, PRDATA=0, all writable registers 0.
REQ-028 Reset mid-transfer SHALL discard the pending write.

Structure
REQ-029 Package apb_regbank_pkg SHALL hold the state enum type and the lane-index and LSB computation functions.
REQ-030 The wait counter SHALL be sub-module apb_wait_ctr (load, decrement, done).

Verification (defaults unless stated)
REQ-031 Write 32'h20122023 to 0x4, then read 0x4 -> PREADY high in the second access cycle, PRDATA=32'h20122023, PSLVERR=0.
REQ-032 Write 32'hAABBCCDD to 0x8 with PSTRB=4'b0101 over prior value 0 -> read returns 32'h00BB00DD.
REQ-033 Read 0x20, write 0x6, and write 0x0 -> PSLVERR=1 with PREADY in each; registers unchanged; read 0x0 returns 32'h00000006.
REQ-034 Drop PSEL during the WAIT cycle of a write of 32'h12345678 to 0xC -> no PREADY, 0xC still reads 0.
REQ-035 Assert PRESET=0 mid-write, then release -> all outputs 0, every register except register 0 reads 0.
REQ-036 WAIT_STATES=0 back-to-back writes to 0x4 and 0x8 -> PREADY=1 in each first access cycle; both values read back.
